serial_word_adder: RTL
======================

# serial_word_adder

Parametrised bit-serial adder/subtractor. It accepts two WIDTH-bit operands in parallel on a start strobe, processes them LSB-first at one bit per clock through a single full-adder slice with a registered carry, and streams each sum bit out serially as it is produced. On completion it presents the parallel result, carry/borrow and signed overflow with a one-cycle done pulse. It is the word-level, mode-selectable successor to the team's single-bit serial adder, used wherever area matters more than latency.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  request; sampled only in IDLE.
- sub  input  1  mode, captured with start: 0 = a + b + cin, 1 = a - b - cin.
- cin  input  1  carry-in (add) or borrow-in (sub), captured with start.
- a  input  WIDTH  operand A, captured with start.
- b  input  WIDTH  operand B, captured with start.
- busy  output  1  high while an operation is in progress.
- s  output  1  current serial sum bit, LSB first.
- s_valid  output  1  qualifies s.
- done  output  1  one-cycle completion pulse.
- sum  output  WIDTH  parallel result, held until the next completion.
- cout  output  1  final carry-out; in sub mode 1 = no borrow.
- ovf  output  1  signed (two's-complement) overflow of the result.

## Operation
- FSM with two states: IDLE and RUN. Bit counter cnt is ceil(log2(WIDTH)) bits wide.
- IDLE with start=1 at an edge:
  - latch a into shift register ra;
  - latch b into rb (rb = ~b when sub=1);
  - latch carry c = cin (add) or c = ~cin (sub);
  - cnt <= 0, busy <= 1, state <= RUN.
- IDLE with start=0: all registers hold.
- RUN, each edge, where bit = ra[0]^rb[0]^c and cnext = majority(ra[0], rb[0], c):
  - s <= bit, s_valid <= 1;
  - shift bit into the internal result register rs from the MSB side;
  - ra, rb shift right; c <= cnext; cnt <= cnt+1.
- RUN, edge with cnt == WIDTH-1: additionally
  - sum <= {bit, rs[WIDTH-1:1]};
  - cout <= cnext;
  - ovf <= c ^ cnext, i.e. carry into the MSB XOR carry out of it;
  - done <= 1, busy <= 0, state <= IDLE.
- In any cycle not described above: done <= 0 and s_valid <= 0. s holds its last value.
- Inputs start, a, b, sub and cin are ignored while busy=1. A start seen in RUN is dropped, not queued.
- Width rules:
  - all arithmetic is modulo 2^WIDTH;
  - cout is bit WIDTH of a + b' + c0, where b' is b or ~b per mode and c0 is the initial carry;
  - sum/cout/ovf change only on the completion edge.
- Reset (reset=0, asynchronous, any state, including mid-RUN):
  - state = IDLE, cnt = 0;
  - busy = 0, s = 0, s_valid = 0, done = 0, sum = 0, cout = 0, ovf = 0, ra = rb = rs = 0, c = 0;
  - any in-flight operation is aborted with no done pulse.
- Release of reset is synchronous to the design: the first edge with reset=1 may accept start.

## Timing
- Label the start-accept edge E0.
- After edges E1..EWIDTH: s = result bit i-1 and s_valid = 1, so WIDTH consecutive valid bits.
- busy is high for exactly WIDTH cycles: from after E0 up to, but not including, after EWIDTH.
- After EWIDTH: done = 1, sum/cout/ovf valid, busy = 0, and the final s bit (MSB) is presented.
- Latency from start-accept to done is WIDTH cycles.
- Earliest next accept is EWIDTH+1, which is the cycle in which done is high. Sustained throughput is one operation per WIDTH+1 cycles.
- start held continuously triggers back-to-back operations, each capturing the operands present at its accept edge.

## Test plan
- WIDTH=8, add, a=0x5A, b=0x3C, cin=0 -> s stream LSB-first 0,1,1,0,1,0,0,1; done exactly 8 cycles after accept; sum=0x96, cout=0, ovf=1.
- WIDTH=8, add, a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then add a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- WIDTH=8, sub, a=0x10, b=0x20, cin=0 -> sum=0xF0, cout=0 (borrow), ovf=0. Then sub a=0x80, b=0x01, cin=0 -> sum=0x7F, cout=1, ovf=1. Then sub a=0x05, b=0x03, cin=1 -> sum=0x01, cout=1.
- Start pulsed again and a/b/sub changed during RUN -> no effect: busy stays high for 8 cycles, a single done pulse, result from the originally captured operands.
- reset driven low for 2 ns mid-RUN (cnt=3), asynchronous to clk -> all outputs 0 immediately, no done; a subsequent start completes a fresh operation correctly.
- WIDTH=4 instance, add a=0x7, b=0x1, cin=0 -> 4 s bits 0,0,0,1; sum=0x8, ovf=1, cout=0. start held high for 3 operations -> done every 5 cycles.

Source files
------------

// File: rtl/serial_word_adder.sv
`timescale 1ns/1ps
// serial_word_adder: bit-serial add/subtract of two WIDTH-bit words, LSB first,
// through one full-adder slice with a registered carry.
module serial_word_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             s,
  output logic             s_valid,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] ra;
  logic [WIDTH-1:0] rb;
  logic [WIDTH-1:0] rs;
  logic             c;
  logic             bitv;
  logic             cnext;
  logic             accept;
  logic             last;

  always_comb begin
    bitv       = ra[0] ^ rb[0] ^ c;
    cnext      = (ra[0] & rb[0]) | (ra[0] & c) | (rb[0] & c);
    accept     = 1'b0;
    last       = 1'b0;
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Subtraction is a + ~b + ~borrow, so the slice itself never changes mode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= '0;
      ra      <= '0;
      rb      <= '0;
      rs      <= '0;
      c       <= 1'b0;
      busy    <= 1'b0;
      s       <= 1'b0;
      s_valid <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done    <= 1'b0;
      s_valid <= 1'b0;
      if (accept) begin
        ra   <= a;
        rb   <= sub ? ~b : b;
        c    <= sub ? ~cin : cin;
        cnt  <= '0;
        busy <= 1'b1;
      end else if (state == RUN) begin
        s       <= bitv;
        s_valid <= 1'b1;
        rs      <= {bitv, rs[WIDTH-1:1]};
        ra      <= ra >> 1;
        rb      <= rb >> 1;
        c       <= cnext;
        cnt     <= cnt + CW'(1);
        if (last) begin
          sum  <= {bitv, rs[WIDTH-1:1]};
          cout <= cnext;
          ovf  <= c ^ cnext;
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
